// File: rtl/dcache_responder.sv
// dcache_responder: 8-line direct-mapped write-back data cache terminating the LC-3b mem_* interface.
// Optional feature macro: DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [11:0]  mem_address,
    input  logic [3:0]   line_offset,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [11:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]   r_state;
    logic [7:0]   r_valid;
    logic [7:0]   r_dirty;
    logic [8:0]   r_tag  [8];
    logic [127:0] r_data [8];

    logic [2:0]   w_index;
    logic [8:0]   w_tag;
    logic         w_req;
    logic         w_idle;
    logic         w_hit;
    logic         w_resp;
    logic [127:0] w_line;
    logic [127:0] w_merged;
    logic [15:0]  w_word;
    logic         w_unused_ok;

    assign w_index     = mem_address[2:0];
    assign w_tag       = mem_address[11:3];
    assign w_req       = mem_read | mem_write;
    assign w_idle      = (r_state == S_IDLE);
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_resp      = !rst && w_idle && w_req && w_hit;
    assign w_line      = r_data[w_index];
    assign w_unused_ok = line_offset[0];

    // Word select and byte-lane merge; constant part-select bases keep widths exact.
    always_comb begin
        w_word   = 16'h0000;
        w_merged = w_line;
        for (int w = 0; w < 8; w++) begin
            if (line_offset[3:1] == w[2:0]) begin
                w_word = w_line[w*16 +: 16];
                if (mem_byte_enable[0]) w_merged[w*16 +: 8]     = mem_wdata[7:0];
                if (mem_byte_enable[1]) w_merged[w*16 + 8 +: 8] = mem_wdata[15:8];
            end
        end
    end

    // A simultaneous read and write is served as a write, so no read data is returned.
    assign mem_resp     = w_resp;
    assign mem_rdata    = (w_resp && !mem_write) ? w_word : 16'h0000;
    assign pmem_read    = (r_state == S_FILL);
    assign pmem_write   = (r_state == S_WB);
    assign pmem_address = (r_state == S_WB)   ? {r_tag[w_index], w_index} :
                          (r_state == S_FILL) ? mem_address : 12'h000;
    assign pmem_wdata   = (r_state == S_WB) ? w_line : 128'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 8'h00;
            r_dirty <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? S_WB : S_FILL;
                    end else if (w_resp && mem_write && (mem_byte_enable != 2'b00)) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (pmem_resp) begin
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_FILL) && pmem_resp) begin
            r_data[w_index] <= pmem_rdata;
            r_tag[w_index]  <= w_tag;
        end else if (w_resp && mem_write) begin
            r_data[w_index] <= w_merged;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_missed;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // r_missed marks a request whose eventual response completes a miss, not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_missed     <= 1'b0;
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else if (w_idle && w_req && !w_hit) begin
            r_missed     <= 1'b1;
            r_miss_count <= r_miss_count + 16'h0001;
        end else if (w_resp) begin
            if (r_missed) r_missed    <= 1'b0;
            else          r_hit_count <= r_hit_count + 16'h0001;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
